// File: rtl/reg_alu_pipe.sv
// reg_alu_pipe: DEPTH x WIDTH register file with two combinational read ports,
// an 8-operation ALU on the read-port data, a registered write-back stage and
// registered status flags.
//
// Optional feature macro: REG_ALU_PIPE_FWD_EN
//   defined   -> read ports bypass the pending write-back data
//   undefined -> read ports return the array contents only
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   sel                write-data source (1 = ALU result, 0 = d_in)
//   wr                 write request
//   op                 ALU opcode
//   rd_addr_a/b        read port addresses (also ALU operands A/B)
//   wr_addr            destination register
//   d_in               external write data
//   d_out_a/b          read port data (combinational)
//   cout/zero/neg/ovf  registered ALU status flags
module reg_alu_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic              wr,
  input  logic [2:0]        op,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  d_in,
  output logic [WIDTH-1:0]  d_out_a,
  output logic [WIDTH-1:0]  d_out_b,
  output logic              cout,
  output logic              zero,
  output logic              neg,
  output logic              ovf
);

  localparam int unsigned MSB = WIDTH - 1;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_SHL  = 3'd5;
  localparam logic [2:0] OP_SHR  = 3'd6;
  localparam logic [2:0] OP_PASS = 3'd7;

  logic [WIDTH-1:0]  regs [DEPTH];
  logic              wb_valid;
  logic [ADDR_W-1:0] wb_addr;
  logic [WIDTH-1:0]  wb_data;

  logic [WIDTH-1:0]  alu_res;
  logic [WIDTH:0]    alu_sum;
  logic              alu_cout;
  logic              alu_ovf;

  // Read ports, optionally forwarding the write still sitting in write-back
`ifdef REG_ALU_PIPE_FWD_EN
  assign d_out_a = (wb_valid && (wb_addr == rd_addr_a)) ? wb_data : regs[rd_addr_a];
  assign d_out_b = (wb_valid && (wb_addr == rd_addr_b)) ? wb_data : regs[rd_addr_b];
`else
  assign d_out_a = regs[rd_addr_a];
  assign d_out_b = regs[rd_addr_b];
`endif

  // ALU on the read-port data
  always_comb begin
    alu_sum  = '0;
    alu_res  = '0;
    alu_cout = 1'b0;
    alu_ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        alu_sum  = {1'b0, d_out_a} + {1'b0, d_out_b};
        alu_res  = alu_sum[MSB:0];
        alu_cout = alu_sum[WIDTH];
        alu_ovf  = (d_out_a[MSB] == d_out_b[MSB]) && (alu_res[MSB] != d_out_a[MSB]);
      end
      OP_SUB: begin
        // Extra top bit of the widened difference is the unsigned borrow
        alu_sum  = {1'b0, d_out_a} - {1'b0, d_out_b};
        alu_res  = alu_sum[MSB:0];
        alu_cout = alu_sum[WIDTH];
        alu_ovf  = (d_out_a[MSB] != d_out_b[MSB]) && (alu_res[MSB] != d_out_a[MSB]);
      end
      OP_AND: alu_res = d_out_a & d_out_b;
      OP_OR:  alu_res = d_out_a | d_out_b;
      OP_XOR: alu_res = d_out_a ^ d_out_b;
      OP_SHL: begin
        alu_res  = {d_out_a[MSB-1:0], 1'b0};
        alu_cout = d_out_a[MSB];
      end
      OP_SHR: begin
        alu_res  = {1'b0, d_out_a[MSB:1]};
        alu_cout = d_out_a[0];
      end
      OP_PASS: alu_res = d_out_a;
      default: alu_res = d_out_a;
    endcase
  end

  // Write-back stage and status flags
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      cout     <= 1'b0;
      zero     <= 1'b0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      wb_valid <= wr;
      if (wr) begin
        wb_addr <= wr_addr;
        wb_data <= sel ? alu_res : d_in;
      end
      if (wr && sel) begin
        cout <= alu_cout;
        zero <= (alu_res == '0);
        neg  <= alu_res[MSB];
        ovf  <= alu_ovf;
      end
    end
  end

  // Register array commit; reset drops any pending write-back
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid) begin
      regs[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_reg_alu_pipe.sv
// Self-checking bench for reg_alu_pipe: table of ALU vectors plus hand-written
// sequences for bypass timing, back-to-back writes and reset during write-back.
module tb_reg_alu_pipe;

`ifdef REG_ALU_PIPE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic        wr;
  logic [2:0]  op;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [2:0]  wr_addr;
  logic [15:0] d_in;
  logic [15:0] d_out_a;
  logic [15:0] d_out_b;
  logic        cout;
  logic        zero;
  logic        neg;
  logic        ovf;

  int total = 0;
  int bad   = 0;

  reg_alu_pipe #(.WIDTH(16), .DEPTH(8), .ADDR_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .sel       (sel),
    .wr        (wr),
    .op        (op),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .wr_addr   (wr_addr),
    .d_in      (d_in),
    .d_out_a   (d_out_a),
    .d_out_b   (d_out_b),
    .cout      (cout),
    .zero      (zero),
    .neg       (neg),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a_val;
    logic [15:0] b_val;
    logic [15:0] res;
    logic        c;
    logic        z;
    logic        n;
    logic        v;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_flags(input string name, input logic c, input logic z,
                           input logic n, input logic v);
    chk({name, ".cout"}, 16'(cout), 16'(c));
    chk({name, ".zero"}, 16'(zero), 16'(z));
    chk({name, ".neg"},  16'(neg),  16'(n));
    chk({name, ".ovf"},  16'(ovf),  16'(v));
  endtask

  task automatic write_issue(input logic [2:0] addr, input logic [15:0] val);
    wr = 1'b1; sel = 1'b0; wr_addr = addr; d_in = val;
  endtask

  task automatic write_reg(input logic [2:0] addr, input logic [15:0] val);
    write_issue(addr, val);
    tick();
    wr = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = 1'b0; sel = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{3'd0, 16'hcdef, 16'h3210, 16'hffff, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'd0, 16'hffff, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{3'd0, 16'h7fff, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[3]  = '{3'd1, 16'hcdef, 16'h3210, 16'h9bdf, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'd1, 16'h3210, 16'hcdef, 16'h6421, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd1, 16'h8000, 16'h0001, 16'h7fff, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{3'd1, 16'h0005, 16'h0005, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{3'd2, 16'hcdef, 16'h3210, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{3'd2, 16'hff00, 16'h0ff0, 16'h0f00, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'd3, 16'hcdef, 16'h3210, 16'hffff, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{3'd4, 16'hcdef, 16'h3210, 16'hffff, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{3'd4, 16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{3'd5, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[13] = '{3'd5, 16'h4000, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[14] = '{3'd6, 16'h8001, 16'h0000, 16'h4000, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[15] = '{3'd6, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{3'd7, 16'h8000, 16'h1111, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[17] = '{3'd7, 16'h0000, 16'hffff, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};

    reset = 1'b1; sel = 1'b0; wr = 1'b0; op = 3'd0;
    rd_addr_a = '0; rd_addr_b = '0; wr_addr = '0; d_in = '0;
    #1;
    do_reset();

    // Reset state: every register reads zero on both ports, flags clear
    for (int i = 0; i < 8; i++) begin
      rd_addr_a = 3'(i);
      rd_addr_b = 3'(7 - i);
      #1;
      chk($sformatf("rst_a[%0d]", i), d_out_a, 16'h0000);
      chk($sformatf("rst_b[%0d]", 7 - i), d_out_b, 16'h0000);
    end
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // Write r3, read it on the next cycle (bypass) while writing r7
    write_issue(3'd3, 16'hcdef);
    tick();
    write_issue(3'd7, 16'h3210);
    rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    #1;
    chk("r3_n1", d_out_a, FWD ? 16'hcdef : 16'h0000);
    tick();
    wr = 1'b0;
    #1;
    chk("r3_n2", d_out_a, 16'hcdef);
    chk("r7_n1", d_out_b, FWD ? 16'h3210 : 16'h0000);
    tick();
    chk("r7_n2", d_out_b, 16'h3210);
    chk("r3_n3", d_out_a, 16'hcdef);

    // ADD r3 + r7 -> r5
    sel = 1'b1; wr = 1'b1; op = 3'd0; rd_addr_a = 3'd3; rd_addr_b = 3'd7; wr_addr = 3'd5;
    tick();
    chk_flags("add_r5", 1'b0, 1'b0, 1'b1, 1'b0);

    // Write r1 then immediately ADD r1 + r5 -> r2
    write_issue(3'd1, 16'hba98);
    tick();
    sel = 1'b1; wr = 1'b1; op = 3'd0; rd_addr_a = 3'd1; rd_addr_b = 3'd5; wr_addr = 3'd2;
    tick();
    wr = 1'b0;
    chk_flags("add_fwd", FWD, 1'b0, 1'b1, 1'b0);
    tick();
    rd_addr_a = 3'd2; rd_addr_b = 3'd5;
    #1;
    chk("r2", d_out_a, FWD ? 16'hba97 : 16'hffff);
    chk("r5", d_out_b, 16'hffff);

    // Back-to-back writes to one address: later write wins
    write_issue(3'd4, 16'h1111);
    tick();
    write_issue(3'd4, 16'h2222);
    rd_addr_a = 3'd4;
    tick();
    wr = 1'b0;
    #1;
    chk("b2b_n1", d_out_a, FWD ? 16'h2222 : 16'h1111);
    tick();
    chk("b2b_n2", d_out_a, 16'h2222);

    // SUB r5 - r5 -> r4, then SUB r3 - r7 -> r6
    sel = 1'b1; wr = 1'b1; op = 3'd1; rd_addr_a = 3'd5; rd_addr_b = 3'd5; wr_addr = 3'd4;
    tick();
    chk_flags("sub_zero", 1'b0, 1'b1, 1'b0, 1'b0);
    rd_addr_a = 3'd3; rd_addr_b = 3'd7; wr_addr = 3'd6;
    tick();
    chk_flags("sub_neg", 1'b0, 1'b0, 1'b1, 1'b0);
    wr = 1'b0;
    tick();
    rd_addr_a = 3'd4; rd_addr_b = 3'd6;
    #1;
    chk("r4_sub", d_out_a, 16'h0000);
    chk("r6_sub", d_out_b, 16'h9bdf);

    // Reset while a write is pending in write-back discards it
    write_issue(3'd6, 16'h1234);
    tick();
    reset = 1'b1; wr = 1'b0;
    tick();
    reset = 1'b0;
    rd_addr_a = 3'd6; rd_addr_b = 3'd3;
    #1;
    chk("r6_rst", d_out_a, 16'h0000);
    chk("r3_rst", d_out_b, 16'h0000);
    chk_flags("rst2", 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    chk("r6_rst2", d_out_a, 16'h0000);

    // Flags hold for sel=0 writes and for wr=0
    sel = 1'b1; wr = 1'b1; op = 3'd7; rd_addr_a = 3'd0; wr_addr = 3'd0;
    tick();
    chk_flags("pass_zero", 1'b0, 1'b1, 1'b0, 1'b0);
    write_issue(3'd0, 16'h8000);
    tick();
    chk_flags("hold_sel0", 1'b0, 1'b1, 1'b0, 1'b0);
    wr = 1'b0; sel = 1'b1;
    tick();
    chk_flags("hold_wr0", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("r0_d_in", d_out_a, 16'h8000);

    // Table-driven ALU vectors: operands in r0/r1, result to r2
    for (int k = 0; k < NV; k++) begin
      write_reg(3'd0, vecs[k].a_val);
      write_reg(3'd1, vecs[k].b_val);
      sel = 1'b1; wr = 1'b1; op = vecs[k].op;
      rd_addr_a = 3'd0; rd_addr_b = 3'd1; wr_addr = 3'd2;
      tick();
      wr = 1'b0;
      chk_flags($sformatf("vec%0d", k), vecs[k].c, vecs[k].z, vecs[k].n, vecs[k].v);
      tick();
      rd_addr_a = 3'd2;
      #1;
      chk($sformatf("vec%0d.res", k), d_out_a, vecs[k].res);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
